// File: rtl/exp_sequencer_if.sv
// Request/acknowledge link between the exponent sequencer and the shared
// multiplier datapath.
interface exp_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                 req;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ack;
    logic [2*WIDTH-1:0]   p;

    modport master (output req, a, b, input ack, p);
    modport slave  (input req, a, b, output ack, p);
endinterface

// File: rtl/exp_sequencer.sv
// Square-and-multiply controller: computes base^exponent mod 2^WIDTH with an
// exact overflow flag, driving an external multiplier over a req/ack link.
//
// state | meaning
// IDLE  | waiting for start; operands latched when start is accepted
// CHECK | inspect remaining exponent, pick multiply, square or finish
// MUL   | r <= r*b, waiting for the multiplier
// SQR   | b <= b*b and e <= e>>1, waiting for the multiplier
// DONE  | one-cycle done pulse, result and overflow final
module exp_sequencer #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 10
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      base,
    input  logic [EXP_WIDTH-1:0]  exponent,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic                  overflow,
    exp_sequencer_if.master       mul
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL   = 3'd2,
        SQR   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       r, r_nxt;
    logic [WIDTH-1:0]       b, b_nxt;
    logic [EXP_WIDTH-1:0]   e, e_nxt;
    logic                   ovf, ovf_nxt;
    logic                   hi_nz;

    assign hi_nz    = |mul.p[2*WIDTH-1:WIDTH];
    assign result   = r;
    assign overflow = ovf;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
            r     <= '0;
            b     <= '0;
            e     <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            b     <= b_nxt;
            e     <= e_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        b_nxt     = b;
        e_nxt     = e;
        ovf_nxt   = ovf;
        busy      = 1'b0;
        done      = 1'b0;
        mul.req   = 1'b0;
        mul.a     = '0;
        mul.b     = '0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    r_nxt     = WIDTH'(1);
                    b_nxt     = base;
                    e_nxt     = exponent;
                    ovf_nxt   = 1'b0;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (e == '0)
                    state_nxt = DONE;
                else if (e[0])
                    state_nxt = MUL;
                else
                    state_nxt = SQR;
            end
            MUL: begin
                busy    = 1'b1;
                mul.req = 1'b1;
                mul.a   = r;
                mul.b   = b;
                if (mul.ack) begin
                    r_nxt   = mul.p[WIDTH-1:0];
                    ovf_nxt = ovf | hi_nz;
                    // The last squaring is skipped, which keeps overflow exact.
                    state_nxt = (e[EXP_WIDTH-1:1] == '0) ? DONE : SQR;
                end
            end
            SQR: begin
                busy    = 1'b1;
                mul.req = 1'b1;
                mul.a   = b;
                mul.b   = b;
                if (mul.ack) begin
                    b_nxt     = mul.p[WIDTH-1:0];
                    ovf_nxt   = ovf | hi_nz;
                    e_nxt     = e >> 1;
                    state_nxt = CHECK;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_exp_sequencer.sv
// Self-checking bench for exp_sequencer: directed plan cases plus randomized
// runs against a plain-arithmetic power/overflow/latency model.
module tb_exp_sequencer;

    logic        clk_clk;
    logic        reset_reset;
    logic        start;
    logic [31:0] base;
    logic [9:0]  exponent;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;

    exp_sequencer_if #(.WIDTH(32)) mul_bus ();

    exp_sequencer #(.WIDTH(32), .EXP_WIDTH(10)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .start       (start),
        .base        (base),
        .exponent    (exponent),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overflow    (overflow),
        .mul         (mul_bus)
    );

    int checks = 0;
    int errors = 0;

    int max_delay  = 0;
    bit spurious   = 0;
    int done_cnt   = 0;
    int req_cycles = 0;
    int stab_err   = 0;
    logic [63:0] ops[$];

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: straight repeated multiplication, no square-and-multiply.
    function automatic logic [31:0] ref_pow(input logic [31:0] bs, input int ex);
        logic [31:0] acc = 32'd1;
        for (int i = 0; i < ex; i++) acc = acc * bs;
        return acc;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] bs, input int ex);
        longint unsigned acc = 64'd1;
        if (ex == 0 || bs < 32'd2) return 1'b0;
        for (int i = 0; i < ex; i++) begin
            acc = acc * 64'(bs);
            if (acc >= 64'h1_0000_0000) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int bit_len(input int ex);
        int bl = 0;
        for (int i = 0; i < 10; i++) if (ex[i]) bl = i + 1;
        return bl;
    endfunction

    function automatic int ref_muls(input int ex);
        int pc = 0;
        int bl = bit_len(ex);
        for (int i = 0; i < 10; i++) if (ex[i]) pc++;
        return pc + ((bl > 0) ? bl - 1 : 0);
    endfunction

    function automatic int ref_latency(input int ex);
        int bl = bit_len(ex);
        int visits = (bl == 0) ? 1 : bl;
        return 2 + (visits - 1) + ref_muls(ex);
    endfunction

    // Multiplier model plus bus monitor, evaluated on every falling edge.
    initial begin
        int   wait_cnt = 0;
        bit   active = 0;
        logic prev_req = 1'b0;
        logic prev_ack = 1'b0;
        logic [31:0] prev_a = '0;
        logic [31:0] prev_b = '0;
        mul_bus.ack = 1'b0;
        mul_bus.p   = '0;
        forever begin
            @(negedge clk_clk);
            if (done === 1'b1) done_cnt++;
            if (mul_bus.req === 1'b1) req_cycles++;
            if (prev_req && !prev_ack && mul_bus.req &&
                (mul_bus.a !== prev_a || mul_bus.b !== prev_b)) stab_err++;
            mul_bus.ack = 1'b0;
            mul_bus.p   = '0;
            if (mul_bus.req === 1'b1) begin
                if (!active) begin
                    active   = 1;
                    wait_cnt = $urandom_range(0, max_delay);
                end
                if (wait_cnt == 0) begin
                    mul_bus.ack = 1'b1;
                    mul_bus.p   = 64'(mul_bus.a) * 64'(mul_bus.b);
                    ops.push_back({mul_bus.a, mul_bus.b});
                    active = 0;
                end else begin
                    wait_cnt--;
                end
            end else begin
                active = 0;
                if (spurious && $urandom_range(0, 2) == 0) begin
                    mul_bus.ack = 1'b1;
                    mul_bus.p   = {$urandom, $urandom};
                end
            end
            prev_req = mul_bus.req;
            prev_ack = mul_bus.ack;
            prev_a   = mul_bus.a;
            prev_b   = mul_bus.b;
        end
    end

    task automatic run(input string tag, input logic [31:0] bs, input logic [9:0] ex,
                       input bit disturb);
        int cyc;
        logic [31:0] exp_r;
        logic        exp_o;
        exp_r = ref_pow(bs, int'(ex));
        exp_o = ref_ovf(bs, int'(ex));
        @(negedge clk_clk);
        ops.delete();
        done_cnt   = 0;
        req_cycles = 0;
        stab_err   = 0;
        start    = 1'b1;
        base     = bs;
        exponent = ex;
        @(negedge clk_clk);
        start = 1'b0;
        cyc   = 1;
        chk({tag, "_busy_n1"}, 64'(busy), 64'd1);
        while (done !== 1'b1 && cyc < 5000) begin
            if (disturb) begin
                start    = 1'($urandom_range(0, 1));
                base     = $urandom;
                exponent = 10'($urandom);
            end
            @(negedge clk_clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        if (max_delay == 0) chk({tag, "_latency"}, 64'(cyc), 64'(ref_latency(int'(ex))));
        chk({tag, "_result"}, 64'(result), 64'(exp_r));
        chk({tag, "_overflow"}, 64'(overflow), 64'(exp_o));
        chk({tag, "_mul_count"}, 64'(ops.size()), 64'(ref_muls(int'(ex))));
        start    = 1'b1;
        base     = $urandom;
        exponent = 10'($urandom);
        @(negedge clk_clk);
        start = 1'b0;
        repeat (3) @(negedge clk_clk);
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_held_result"}, 64'(result), 64'(exp_r));
        chk({tag, "_operand_stable"}, 64'(stab_err), 64'd0);
    endtask

    initial begin
        logic [63:0] exp_ops[4];
        int cyc;
        exp_ops[0] = {32'd1, 32'd3};
        exp_ops[1] = {32'd3, 32'd3};
        exp_ops[2] = {32'd9, 32'd9};
        exp_ops[3] = {32'd3, 32'd81};

        reset_reset = 1'b1;
        start       = 1'b0;
        base        = '0;
        exponent    = '0;
        repeat (2) @(negedge clk_clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req", 64'(mul_bus.req), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_mul_a", 64'(mul_bus.a), 64'd0);
        chk("rst_mul_b", 64'(mul_bus.b), 64'd0);
        reset_reset = 1'b0;

        max_delay = 0;
        run("p3_5", 32'd3, 10'd5, 1'b0);
        chk("p3_5_r243", 64'(result), 64'd243);
        chk("p3_5_nops", 64'(ops.size()), 64'd4);
        if (ops.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("p3_5_op%0d", i), ops[i], exp_ops[i]);

        run("p0_0", 32'd0, 10'd0, 1'b0);
        chk("p0_0_no_req", 64'(req_cycles), 64'd0);
        chk("p0_0_r1", 64'(result), 64'd1);

        run("p2_31", 32'd2, 10'd31, 1'b0);
        chk("p2_31_r", 64'(result), 64'h8000_0000);
        chk("p2_31_ovf", 64'(overflow), 64'd0);
        run("p2_32", 32'd2, 10'd32, 1'b0);
        chk("p2_32_r", 64'(result), 64'd0);
        chk("p2_32_ovf", 64'(overflow), 64'd1);
        run("p65536_1", 32'h0001_0000, 10'd1, 1'b0);
        chk("p65536_1_r", 64'(result), 64'h1_0000);
        chk("p65536_1_ovf", 64'(overflow), 64'd0);

        max_delay = 5;
        spurious  = 1;
        run("p7_10", 32'd7, 10'd10, 1'b1);
        chk("p7_10_r", 64'(result), 64'd282475249);
        chk("p7_10_ovf", 64'(overflow), 64'd0);

        // Reset while the first squaring (7*7) is outstanding.
        @(negedge clk_clk);
        start    = 1'b1;
        base     = 32'd7;
        exponent = 10'd10;
        @(negedge clk_clk);
        start = 1'b0;
        cyc   = 0;
        while (mul_bus.req !== 1'b1 && cyc < 50) begin
            @(negedge clk_clk);
            cyc++;
        end
        chk("rsq_req_seen", 64'(mul_bus.req), 64'd1);
        chk("rsq_a", 64'(mul_bus.a), 64'd7);
        chk("rsq_b", 64'(mul_bus.b), 64'd7);
        reset_reset = 1'b1;
        @(negedge clk_clk);
        chk("rsq_busy", 64'(busy), 64'd0);
        chk("rsq_req", 64'(mul_bus.req), 64'd0);
        chk("rsq_result", 64'(result), 64'd0);
        chk("rsq_done", 64'(done), 64'd0);
        reset_reset = 1'b0;
        run("p5_3", 32'd5, 10'd3, 1'b0);
        chk("p5_3_r", 64'(result), 64'd125);

        for (int n = 0; n < 14; n++) begin
            logic [31:0] rb;
            logic [9:0]  re;
            max_delay = (n % 3 == 0) ? 0 : $urandom_range(1, 5);
            rb = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
            re = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 40)) : 10'($urandom);
            run($sformatf("rnd%0d", n), rb, re, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_sequencer.md
# exp_sequencer

Square-and-multiply controller for the exponent accelerator. It computes base^exponent (mod 2^WIDTH) by sequencing a shared external multiplier through a req/ack handshake. It flags any loss of precision. It sits between the switch/register front end, which supplies operands and start, and the multiplier datapath. Its result and done outputs feed the LEDR/HEX display logic.

## Interface
Parameters:
- WIDTH, 32, width of the base, result and multiplier operands.
- EXP_WIDTH, 10, exponent width (matches the 10 board switches).

Ports:
- clk_clk  in  1  system clock; all logic is on the rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- start  in  1  request a computation; sampled only in IDLE.
- base  in  WIDTH  operand, latched on accepted start.
- exponent  in  EXP_WIDTH  unsigned exponent, latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the last cycle before DONE.
- done  out  1  single-cycle pulse; result and overflow are valid from this cycle onward.
- result  out  WIDTH  low WIDTH bits of base^exponent; held until the next accepted start.
- overflow  out  1  true result ≥ 2^WIDTH; held with result.
- mul_req  out  1  multiply request.
- mul_a, mul_b  out  WIDTH  multiplier operands; stable while mul_req=1.
- mul_ack  in  1  multiplier completion; mul_p is valid in the same cycle.
- mul_p  in  2*WIDTH  full product.

## Operation
Internal registers:
- r: WIDTH-bit accumulator.
- b: WIDTH-bit running square.
- e: EXP_WIDTH-bit remaining exponent.

States and transitions:
- IDLE:
  - start=1 → r<=1, b<=base, e<=exponent, overflow<=0, go CHECK.
  - start=0 → stay.
- CHECK (1 cycle):
  - e==0 → DONE.
  - else e[0]=1 → MUL.
  - else → SQR.
- MUL:
  - mul_req=1, mul_a=r, mul_b=b.
  - On mul_ack: r<=mul_p[WIDTH-1:0]; overflow|=(mul_p[2W-1:W]!=0).
  - Then if e[EXP_WIDTH-1:1]==0 → DONE, else → SQR.
- SQR:
  - mul_req=1, mul_a=b, mul_b=b.
  - On mul_ack: b<=mul_p low half; overflow|=(high half!=0); e<=e>>1; go CHECK.
- DONE (1 cycle): done=1, busy=0, then go IDLE.

Rules:
- The final square is never issued, because a squaring is only reached when higher exponent bits remain. The overflow flag is therefore exact, not conservative.
- Operand registers change only on an accepted start; later changes to base or exponent have no effect on the running computation.
- start while not in IDLE is ignored, including the DONE cycle. It is not queued.
- mul_ack while mul_req=0 is ignored.
- result is r; it shows the in-progress value while busy and the final value after done.

## Timing
Reset (reset_reset=1 at an edge):
- State becomes IDLE; busy=0, done=0, mul_req=0, result=0, overflow=0, mul_a=mul_b=0.
- Reset takes priority over start and mul_ack in the same cycle.
- Reset mid-operation abandons the computation. mul_req is low from the next cycle, and a late mul_ack is ignored.

Cycle timing:
- Start accepted at edge N → busy=1 from cycle N+1 (CHECK).
- mul_req rises the cycle after entering MUL/SQR from CHECK. MUL→SQR keeps mul_req high, with new operands from the next cycle.
- mul_req is held with stable mul_a/mul_b until the edge where mul_ack=1. It deasserts on that edge unless the next state is another multiply state.
- A zero-wait multiplier (ack in the first request cycle) completes each multiply in 1 cycle.
- Zero-wait latency from accepted start to done:
  - exponent=0: done in cycle N+2.
  - In general: 2 + (#CHECK visits − 1) + (#multiplies).
  - Each multiplier wait cycle adds exactly 1 cycle.

## Test plan
- base=3, exponent=5, zero-wait multiplier → four multiplies in order (1·3, 3·3, 9·9, 3·81), result=243, overflow=0, single done pulse.
- base=0, exponent=0 → no mul_req ever asserted, done at N+2, result=1, overflow=0.
- WIDTH=32: base=2, exponent=31 → result=0x80000000, overflow=0. base=2, exponent=32 → result=0, overflow=1. base=0x10000, exponent=1 → result=0x10000, overflow=0 (no square issued).
- Multiplier with random 0–5 cycle ack delay and spurious mul_ack while idle, base=7, exponent=10 → result=282475249, overflow=0; mul_a/mul_b never change while mul_req=1.
- start pulsed during busy and during the DONE cycle, with base/exponent changed mid-run → ignored; result matches the originally latched operands; exactly one done.
- reset_reset asserted in SQR while mul_req=1 → next cycle busy=0, mul_req=0, result=0. A following start with base=5, exponent=3 → result=125.
